// File: rtl/gear_adder_seq.sv
// Sequential GeAr(N,R,P) approximate adder with optional carry-error correction.
// Approximate mode returns the all-zero-carry GeAr sum; exact mode repairs one sub-adder per cycle.
module gear_adder_seq #(
  parameter  int N  = 8,
  parameter  int R  = 1,
  parameter  int P  = 2,
  localparam int L  = R + P,
  localparam int K  = (N - L) / R + 1,
  localparam int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    res,
  output logic          err_flag,
  output logic [CW-1:0] corr_cnt
);

  localparam int NW = N + 1;
  localparam int LW = L + 1;
  localparam int RW = R + 1;

  if (((N - L) % R) != 0 || K < 2) begin : g_illegal_params
    $fatal(1, "gear_adder_seq: illegal GeAr parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CORR,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic [K-1:0]   c_q, c_d;
  logic [N:0]     res_q, res_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [N:0]     sum_now, sum_fix;
  logic [K-1:0]   mis_now, mis_fix;
  logic [K-1:0]   fix, c_fix;

  // Each sub-adder sums its L-bit window with its own carry-in; only its top R bits reach the result.
  function automatic logic [N:0] gear_sum(input logic [N-1:0] a,
                                          input logic [N-1:0] b,
                                          input logic [K-1:0] c);
    logic [N:0]   r;
    logic [L-1:0] wa, wb;
    logic [L:0]   s;
    r = '0;
    for (int i = 0; i < K; i++) begin
      wa = L'(a >> (i * R));
      wb = L'(b >> (i * R));
      s  = {1'b0, wa} + {1'b0, wb} + LW'(c[i]);
      if (i == 0) begin
        r = r | NW'(s[L-1:0]);
      end else begin
        r = r | (NW'(s[L-1:P]) << (i * R + P));
      end
      if (i == K - 1) begin
        r = r | (NW'(s[L]) << N);
      end
    end
    return r;
  endfunction

  // A mismatch means the predicted carry-in disagrees with the carry the sub-adder below produces.
  function automatic logic [K-1:0] gear_mis(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [K-1:0] c);
    logic [K-1:0] m;
    logic [R:0]   t;
    m = '0;
    for (int i = 1; i < K; i++) begin
      t    = {1'b0, R'(a >> ((i - 1) * R))} + {1'b0, R'(b >> ((i - 1) * R))} + RW'(c[i-1]);
      m[i] = c[i] ^ t[R];
    end
    return m;
  endfunction

  // Look ahead past the pending correction so the final repair and the move to DONE share a cycle.
  always_comb begin
    sum_now = gear_sum(a_q, b_q, c_q);
    mis_now = gear_mis(a_q, b_q, c_q);
    fix     = mis_now & (~mis_now + K'(1));
    c_fix   = c_q | fix;
    sum_fix = gear_sum(a_q, b_q, c_fix);
    mis_fix = gear_mis(a_q, b_q, c_fix);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    c_d         = c_q;
    res_d       = res_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = in1;
          b_d        = in2;
          mode_d     = mode;
          c_d        = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        err_d = |mis_now;
        res_d = sum_now;
        if (!mode_q || (mis_now == '0)) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        c_d   = c_fix;
        cnt_d = cnt_q + CW'(1);
        res_d = sum_fix;
        if (mis_fix == '0) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      c_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      c_q         <= c_d;
      res_q       <= res_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign err_flag  = err_q;
  assign corr_cnt  = cnt_q;

endmodule
